// File: rtl/i2s_rx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_rx
// Purpose  : I2S slave receiver. Synchronises external SCK/WS/SD into pclk,
//            deserialises MSB-first words and pushes them into per-channel
//            first-word-fall-through FIFOs with sticky overflow flags.
// Options  : define I2S_RX_IRQ_EN to add a registered irq output
//            (overflow on either channel or data available in either FIFO).
// Revision : 1.0 - initial release
// ============================================================================
module i2s_rx #(
    parameter int DATA_W      = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              i2s_enable,
    input  logic              i2s_sck_i,
    input  logic              i2s_ws_i,
    input  logic              i2s_sd_i,
    input  logic              rxl_pop,
    input  logic              rxr_pop,
    input  logic              ovf_clr,
    output logic [DATA_W-1:0] rxl_data,
    output logic [DATA_W-1:0] rxr_data,
`ifdef I2S_RX_IRQ_EN
    output logic              irq,
`endif
    output logic              fifol_empty,
    output logic              fifol_full,
    output logic              fifor_empty,
    output logic              fifor_full,
    output logic              ovf_l,
    output logic              ovf_r
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_BIT_W = $clog2(DATA_W + 1);
    localparam int c_IDX_W = $clog2(DATA_W);

    localparam logic [c_BIT_W-1:0] c_BIT_ONE   = c_BIT_W'(1);
    localparam logic [c_BIT_W-1:0] c_DATA_CNT  = c_BIT_W'(DATA_W);
    localparam logic [c_BIT_W-1:0] c_MSB_CNT   = c_BIT_W'(DATA_W - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SYNC = 2'd1;
    localparam logic [1:0] c_ST_RECV = 2'd2;

    // ------------------------------------------------------------------
    // Input synchronisers: bit 2 = SCK, bit 1 = WS, bit 0 = SD
    // ------------------------------------------------------------------
    logic [2:0] sync_q [SYNC_STAGES];
    logic [2:0] sync_d [SYNC_STAGES];
    logic       sck_prev_q, sck_prev_d;
    logic       w_sck_s, w_ws_s, w_sd_s;
    logic       w_sck_rise, w_ws_edge;

    // Shift the three raw inputs down the synchroniser chain
    always_comb begin
        sync_d[0] = {i2s_sck_i, i2s_ws_i, i2s_sd_i};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign w_sck_s    = sync_q[SYNC_STAGES-1][2];
    assign w_ws_s     = sync_q[SYNC_STAGES-1][1];
    assign w_sd_s     = sync_q[SYNC_STAGES-1][0];
    assign sck_prev_d = w_sck_s;
    assign w_sck_rise = w_sck_s & ~sck_prev_q;

    // Synchroniser and edge-detect registers
    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            sck_prev_q <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            sck_prev_q <= sck_prev_d;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM and deserialiser
    // ------------------------------------------------------------------
    logic [1:0]         state_q, state_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [c_BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic               ws_prev_q, ws_prev_d;
    logic               push_q, push_d;
    logic [DATA_W-1:0]  push_word_q, push_word_d;
    logic               push_sel_q, push_sel_d;
    logic [DATA_W-1:0]  w_shift_ins;
    logic [c_IDX_W-1:0] w_bit_idx;

    assign w_ws_edge = (w_ws_s != ws_prev_q);

    // State and datapath registers
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= c_ST_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            ws_prev_q   <= 1'b0;
            push_q      <= 1'b0;
            push_word_q <= '0;
            push_sel_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            ws_prev_q   <= ws_prev_d;
            push_q      <= push_d;
            push_word_q <= push_word_d;
            push_sel_q  <= push_sel_d;
        end
    end

    // Next state: disable always wins; SYNC leaves on the first WS transition
    always_comb begin
        state_d = state_q;
        if (!i2s_enable) begin
            state_d = c_ST_IDLE;
        end else begin
            case (state_q)
                c_ST_IDLE: state_d = c_ST_SYNC;
                c_ST_SYNC: if (w_sck_rise && w_ws_edge) state_d = c_ST_RECV;
                c_ST_RECV: state_d = c_ST_RECV;
                default:   state_d = c_ST_IDLE;
            endcase
        end
    end

    // Deserialiser: capture bits MSB first, emit a word on each WS transition
    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        ws_prev_d   = ws_prev_q;
        push_d      = 1'b0;
        push_word_d = push_word_q;
        push_sel_d  = push_sel_q;
        w_bit_idx   = c_IDX_W'(c_MSB_CNT - bit_cnt_q);
        w_shift_ins = shift_q;
        // Bits past DATA_W are dropped so long words keep their MSBs
        if (bit_cnt_q < c_DATA_CNT) begin
            w_shift_ins[w_bit_idx] = w_sd_s;
        end

        if (w_sck_rise) begin
            ws_prev_d = w_ws_s;
        end

        if (!i2s_enable || state_q == c_ST_IDLE) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end else if (w_sck_rise) begin
            if (state_q == c_ST_SYNC) begin
                // The bit on the WS transition closes the discarded partial word
                if (w_ws_edge) begin
                    shift_d   = '0;
                    bit_cnt_d = '0;
                end
            end else if (state_q == c_ST_RECV) begin
                if (w_ws_edge) begin
                    // WS leads by one bit: this bit is the LSB of the old channel's word
                    push_d      = 1'b1;
                    push_word_d = w_shift_ins;
                    push_sel_d  = ws_prev_q;
                    shift_d     = '0;
                    bit_cnt_d   = '0;
                end else begin
                    shift_d = w_shift_ins;
                    if (bit_cnt_q < c_DATA_CNT) begin
                        bit_cnt_d = bit_cnt_q + c_BIT_ONE;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel FIFOs: index 0 = left, 1 = right
    // ------------------------------------------------------------------
    logic              w_pop_req [2];
    logic [DATA_W-1:0] w_head    [2];
    logic              w_empty   [2];
    logic              w_full    [2];
    logic              w_ovf     [2];

    assign w_pop_req[0] = rxl_pop;
    assign w_pop_req[1] = rxr_pop;

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        localparam logic c_SEL = (ch == 1);

        logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
        logic [DATA_W-1:0]  mem_d [FIFO_DEPTH];
        logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
        logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
        logic [c_CNT_W-1:0] count_q, count_d;
        logic               empty_q, empty_d;
        logic               full_q, full_d;
        logic               ovf_q, ovf_d;
        logic               w_req_push, w_do_push, w_do_pop;

        assign w_req_push = push_q && (push_sel_q == c_SEL);

        // FIFO update: a pop on a full FIFO frees the slot for a same-cycle push
        always_comb begin
            w_do_pop  = w_pop_req[ch] && !empty_q;
            w_do_push = w_req_push && (!full_q || w_do_pop);
            mem_d     = mem_q;
            wr_ptr_d  = wr_ptr_q;
            rd_ptr_d  = rd_ptr_q;
            count_d   = count_q;
            if (w_do_push) begin
                mem_d[wr_ptr_q] = push_word_q;
                wr_ptr_d        = wr_ptr_q + c_PTR_ONE;
            end
            if (w_do_pop) begin
                rd_ptr_d = rd_ptr_q + c_PTR_ONE;
            end
            if (w_do_push && !w_do_pop) begin
                count_d = count_q + c_CNT_ONE;
            end else if (!w_do_push && w_do_pop) begin
                count_d = count_q - c_CNT_ONE;
            end
            empty_d = (count_d == '0);
            full_d  = (count_d == c_DEPTH_CNT);
            ovf_d   = (ovf_q && !ovf_clr) || (w_req_push && !w_do_push);
        end

        // FIFO storage, pointers and registered status
        always_ff @(posedge pclk) begin
            if (preset) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                empty_q  <= 1'b1;
                full_q   <= 1'b0;
                ovf_q    <= 1'b0;
            end else begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    mem_q[i] <= mem_d[i];
                end
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
                empty_q  <= empty_d;
                full_q   <= full_d;
                ovf_q    <= ovf_d;
            end
        end

        assign w_head[ch]  = empty_q ? '0 : mem_q[rd_ptr_q];
        assign w_empty[ch] = empty_q;
        assign w_full[ch]  = full_q;
        assign w_ovf[ch]   = ovf_q;
    end

    assign rxl_data    = w_head[0];
    assign rxr_data    = w_head[1];
    assign fifol_empty = w_empty[0];
    assign fifol_full  = w_full[0];
    assign fifor_empty = w_empty[1];
    assign fifor_full  = w_full[1];
    assign ovf_l       = w_ovf[0];
    assign ovf_r       = w_ovf[1];

`ifdef I2S_RX_IRQ_EN
    logic irq_q, irq_d;

    assign irq_d = w_ovf[0] | w_ovf[1] | ~w_empty[0] | ~w_empty[1];

    // Interrupt: any overflow or any channel holding data
    always_ff @(posedge pclk) begin
        if (preset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule
`default_nettype wire
